// File: rtl/lo_sweep_if.sv
// LO sweep sequencer bus: configuration, sweep control, external-LO request/grant,
// and LO/measurement status. The LO_SWEEP_STEP_COUNT_EN macro adds step_count.
//
// Handshake semantics: start is a level request that is accepted only on a cycle
// where the sequencer is idle, abort is low and ext_req is low. Configuration is
// captured on that same cycle. Any other start is dropped. ext_req/ext_gnt is a
// request/grant pair: ext_gnt follows ext_req one cycle later in every state, and
// the sweep stays parked while ext_req is held high.
interface lo_sweep_if #(
    parameter int SETTING_W = 3,
    parameter int DWELL_W   = 16
);
    logic                 start;
    logic                 abort;
    logic                 cont_mode;
    logic [SETTING_W-1:0] start_code;
    logic [SETTING_W-1:0] stop_code;
    logic [DWELL_W-1:0]   dwell;
    logic                 ext_req;
    logic                 ext_gnt;
    logic [SETTING_W-1:0] lo_setting;
    logic                 lo_en;
    logic                 meas_valid;
    logic                 busy;
    logic                 done;
    logic [2:0]           dbg_state;
`ifdef LO_SWEEP_STEP_COUNT_EN
    logic [7:0]           step_count;
`endif

    modport master (
        output start, abort, cont_mode, start_code, stop_code, dwell, ext_req,
        input  ext_gnt, lo_setting, lo_en, meas_valid, busy, done, dbg_state
`ifdef LO_SWEEP_STEP_COUNT_EN
        , input step_count
`endif
    );

    modport slave (
        input  start, abort, cont_mode, start_code, stop_code, dwell, ext_req,
        output ext_gnt, lo_setting, lo_en, meas_valid, busy, done, dbg_state
`ifdef LO_SWEEP_STEP_COUNT_EN
        , output step_count
`endif
    );
endinterface

// File: rtl/lo_sweep_sequencer.sv
// Steps the mixer LO setting code from start_code to stop_code (wrapping modulo
// 2^SETTING_W), with a settle interval then a measurement dwell per code. An
// external LO owner can preempt the sweep; the sweep resumes at the same code.
// Optional macro LO_SWEEP_STEP_COUNT_EN adds a saturating completed-step counter.
module lo_sweep_sequencer #(
    parameter int SETTING_W     = 3,
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic      clk,
    input  logic      rst,
    lo_sweep_if.slave bus
);
    localparam int CNT_W = (DWELL_W > $clog2(SETTLE_CYCLES + 1)) ? DWELL_W
                                                                 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state, state_n;
    logic [SETTING_W-1:0] code, code_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [SETTING_W-1:0] start_q, stop_q;
    logic [CNT_W-1:0]     dwell_load_q;
    logic                 cont_q;
    logic                 accept, dwell_done;
    logic [CNT_W-1:0]     dwell_load;

    logic                 ext_gnt_r, lo_en_r, meas_valid_r, busy_r, done_r;
    logic [SETTING_W-1:0] lo_setting_r;

    // dwell of 0 behaves as 1; the counter is loaded with the cycle count minus one
    always_comb begin
        dwell_load = '0;
        if (bus.dwell != '0) dwell_load = CNT_W'(bus.dwell - DWELL_W'(1));
    end

    // next-state logic: abort beats ext_req, which beats counter progress
    always_comb begin
        state_n    = state;
        code_n     = code;
        cnt_n      = cnt;
        accept     = 1'b0;
        dwell_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort && !bus.ext_req) begin
                    accept  = 1'b1;
                    code_n  = bus.start_code;
                    cnt_n   = SETTLE_LOAD;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort)               state_n = S_IDLE;
                else if (bus.ext_req)        state_n = S_HOLD;
                else if (cnt == '0) begin
                    cnt_n   = dwell_load_q;
                    state_n = S_DWELL;
                end else                     cnt_n = cnt - CNT_W'(1);
            end
            S_DWELL: begin
                if (bus.abort)               state_n = S_IDLE;
                else if (bus.ext_req)        state_n = S_HOLD;
                else if (cnt == '0) begin
                    dwell_done = 1'b1;
                    cnt_n      = SETTLE_LOAD;
                    if (code != stop_q) begin
                        code_n  = code + SETTING_W'(1);
                        state_n = S_SETTLE;
                    end else if (cont_q) begin
                        code_n  = start_q;
                        state_n = S_SETTLE;
                    end else begin
                        state_n = S_DONE;
                    end
                end else                     cnt_n = cnt - CNT_W'(1);
            end
            S_HOLD: begin
                if (bus.abort)               state_n = S_IDLE;
                else if (!bus.ext_req) begin
                    cnt_n   = SETTLE_LOAD;
                    state_n = S_SETTLE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // state, counters, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            code         <= '0;
            cnt          <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            dwell_load_q <= '0;
            cont_q       <= 1'b0;
            ext_gnt_r    <= 1'b0;
            lo_setting_r <= '0;
            lo_en_r      <= 1'b0;
            meas_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state <= state_n;
            code  <= code_n;
            cnt   <= cnt_n;
            if (accept) begin
                start_q      <= bus.start_code;
                stop_q       <= bus.stop_code;
                dwell_load_q <= dwell_load;
                cont_q       <= bus.cont_mode;
            end
            ext_gnt_r    <= bus.ext_req;
            lo_setting_r <= (state_n == S_IDLE) ? '0 : code_n;
            lo_en_r      <= (state_n == S_SETTLE) || (state_n == S_DWELL);
            meas_valid_r <= (state_n == S_DWELL);
            busy_r       <= (state_n == S_SETTLE) || (state_n == S_DWELL) || (state_n == S_HOLD);
            done_r       <= (state_n == S_DONE);
        end
    end

    assign bus.ext_gnt    = ext_gnt_r;
    assign bus.lo_setting = lo_setting_r;
    assign bus.lo_en      = lo_en_r;
    assign bus.meas_valid = meas_valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.dbg_state  = state;

`ifdef LO_SWEEP_STEP_COUNT_EN
    logic [7:0] step_q;

    // count completed dwells since the last accepted start, saturating at 255
    always_ff @(posedge clk) begin
        if (rst)                               step_q <= 8'd0;
        else if (accept)                       step_q <= 8'd0;
        else if (dwell_done && step_q != 8'hFF) step_q <= step_q + 8'd1;
    end

    assign bus.step_count = step_q;
`endif
endmodule

// File: tb/tb_lo_sweep_sequencer.sv
// Scoreboard bench for lo_sweep_sequencer (default SETTLE_CYCLES=8). Each scenario
// pushes its full expected per-cycle output trace, then drives stimulus; the monitor
// pops and compares on every falling edge while expectations are pending.
// Trace word layout: {ext_gnt, lo_setting[2:0], lo_en, meas_valid, busy, done}.
module tb_lo_sweep_sequencer;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   trace_idx;
    logic [W-1:0] exp_q[$];

    lo_sweep_if #(.SETTING_W(3), .DWELL_W(16)) bus ();

    lo_sweep_sequencer #(.SETTING_W(3), .DWELL_W(16), .SETTLE_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // monitor: compare the DUT outputs against the head of the expected queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, act_v;
            exp_v = exp_q.pop_front();
            act_v = {bus.ext_gnt, bus.lo_setting, bus.lo_en, bus.meas_valid, bus.busy, bus.done};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL trace[%0d] {gnt,code,en,mv,busy,done} got=%b_%b_%b%b%b%b want=%b_%b_%b%b%b%b",
                         trace_idx, act_v[7], act_v[6:4], act_v[3], act_v[2], act_v[1], act_v[0],
                         exp_v[7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
            trace_idx++;
        end
    end

    // driver / expectation tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] vec(input logic g, input logic [2:0] c, input logic en,
                                         input logic mv, input logic b, input logic d);
        return {g, c, en, mv, b, d};
    endfunction

    task automatic push_idle(input int n, input logic g);
        repeat (n) exp_q.push_back(vec(g, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_code(input logic [2:0] c, input int settle_n, input int dwell_n);
        repeat (settle_n) exp_q.push_back(vec(1'b0, c, 1'b1, 1'b0, 1'b1, 1'b0));
        repeat (dwell_n)  exp_q.push_back(vec(1'b0, c, 1'b1, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic push_hold(input logic [2:0] c, input int n);
        repeat (n) exp_q.push_back(vec(1'b1, c, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic push_done(input logic [2:0] c);
        exp_q.push_back(vec(1'b0, c, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic set_cfg(input logic [2:0] sc, input logic [2:0] pc,
                           input logic [15:0] dw, input logic cm);
        bus.start_code = sc;
        bus.stop_code  = pc;
        bus.dwell      = dw;
        bus.cont_mode  = cm;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected cycles still pending after cycle budget", exp_q.size());
            exp_q.delete();
        end
        tick(1);
    endtask

`ifdef LO_SWEEP_STEP_COUNT_EN
    task automatic check_steps(input logic [7:0] want);
        checks++;
        if (bus.step_count !== want) begin
            errors++;
            $display("FAIL step_count got=%0d want=%0d", bus.step_count, want);
        end
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        trace_idx = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ext_req = 1'b0;
        set_cfg(3'd0, 3'd0, 16'd0, 1'b0);

        // reset state
        tick(2);
        push_idle(3, 1'b0);
        tick(2);
        rst = 1'b0;
        drain();
`ifdef LO_SWEEP_STEP_COUNT_EN
        check_steps(8'd0);
`endif

        // 1: codes 2,3,4, dwell 3, single pass -> 11 cycles per code, then done
        set_cfg(3'd2, 3'd4, 16'd3, 1'b0);
        push_idle(1, 1'b0);
        push_code(3'd2, 8, 3);
        push_code(3'd3, 8, 3);
        push_code(3'd4, 8, 3);
        push_done(3'd4);
        push_idle(2, 1'b0);
        start_pulse();
        drain();
`ifdef LO_SWEEP_STEP_COUNT_EN
        check_steps(8'd3);
`endif

        // 2: wrap-around 6,7,0,1 with dwell 1
        set_cfg(3'd6, 3'd1, 16'd1, 1'b0);
        push_idle(1, 1'b0);
        push_code(3'd6, 8, 1);
        push_code(3'd7, 8, 1);
        push_code(3'd0, 8, 1);
        push_code(3'd1, 8, 1);
        push_done(3'd1);
        push_idle(2, 1'b0);
        start_pulse();
        drain();

        // 3: single code 5 in continuous mode, dwell 2; abort during 3rd settle
        set_cfg(3'd5, 3'd5, 16'd2, 1'b1);
        push_idle(1, 1'b0);
        push_code(3'd5, 8, 2);
        push_code(3'd5, 8, 2);
        push_code(3'd5, 5, 0);
        push_idle(3, 1'b0);
        start_pulse();
        tick(24);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        drain();

        // 4: ext_req on 2nd dwell cycle of code 3, held 3 cycles, then resume at code 3
        set_cfg(3'd3, 3'd4, 16'd3, 1'b0);
        push_idle(1, 1'b0);
        push_code(3'd3, 8, 2);
        push_hold(3'd3, 3);
        push_code(3'd3, 8, 3);
        push_code(3'd4, 8, 3);
        push_done(3'd4);
        push_idle(2, 1'b0);
        start_pulse();
        tick(9);
        bus.ext_req = 1'b1;
        tick(3);
        bus.ext_req = 1'b0;
        drain();

        // 5a: dwell 0 acts as 1; start re-pulsed mid-sweep with a new range is ignored
        set_cfg(3'd0, 3'd1, 16'd0, 1'b0);
        push_idle(1, 1'b0);
        push_code(3'd0, 8, 1);
        push_code(3'd1, 8, 1);
        push_done(3'd1);
        push_idle(2, 1'b0);
        start_pulse();
        tick(3);
        set_cfg(3'd6, 3'd7, 16'd5, 1'b1);
        start_pulse();
        drain();

        // 5b: start while ext_req is high in IDLE is ignored; only the grant follows
        push_idle(1, 1'b0);
        push_idle(1, 1'b1);
        push_idle(2, 1'b0);
        bus.start   = 1'b1;
        bus.ext_req = 1'b1;
        tick(1);
        bus.start   = 1'b0;
        bus.ext_req = 1'b0;
        drain();

        // 6: reset during the first dwell cycle of code 2
        set_cfg(3'd2, 3'd4, 16'd3, 1'b0);
        push_idle(1, 1'b0);
        push_code(3'd2, 8, 1);
        push_idle(3, 1'b0);
        start_pulse();
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        drain();
`ifdef LO_SWEEP_STEP_COUNT_EN
        check_steps(8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lo_sweep_sequencer.md
Name: lo_sweep_sequencer

Overview:
Sequences the mixer's internal LO setting code through a programmed range. It drives the 3-bit LO setting and LO enable into the mixer control block, and inserts a settle interval after every code change before flagging a valid measurement window. It also arbitrates LO ownership between the sweep and an external-LO requester, which preempts the sweep and hands back control without losing sweep position.

Parameters:
SETTING_W, 3, width of LO setting code (sweep steps modulo 2^SETTING_W)
DWELL_W, 16, width of dwell-cycle count
SETTLE_CYCLES, 8, cycles of LO settling after each code change (must be >=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  start sweep; sampled only in IDLE
abort  input  1  terminate sweep; highest priority
cont_mode  input  1  1 = restart from start_code after stop_code; 0 = single pass
start_code  input  SETTING_W  first LO code
stop_code  input  SETTING_W  last LO code
dwell  input  DWELL_W  measurement cycles per code; 0 is treated as 1
ext_req  input  1  external LO owner requests the LO
ext_gnt  output  1  grant to external owner
lo_setting  output  SETTING_W  LO code to mixer control
lo_en  output  1  internal LO enable
meas_valid  output  1  LO settled; measurement window open
busy  output  1  sweep in progress (any state except IDLE/DONE)
done  output  1  one-cycle pulse at normal completion of a single pass

Behaviour:
- All outputs are registered. On rst, the state is IDLE and every output is 0, including lo_setting and ext_gnt.
- ext_gnt <= ext_req every cycle in every state, giving a 1-cycle latency.
- start_code, stop_code, dwell and cont_mode are latched on the cycle start is accepted. Later input changes are ignored until the next start.
- States:
  - IDLE: all outputs 0 except ext_gnt. If start=1 and abort=0 and ext_req=0: code=start_code, settle counter=SETTLE_CYCLES-1, go to SETTLE. If ext_req=1, start is ignored.
  - SETTLE: lo_en=1, busy=1, meas_valid=0. Counter decrements each cycle. At 0: dwell counter=max(dwell,1)-1, go to DWELL.
  - DWELL: lo_en=1, busy=1, meas_valid=1. Counter decrements each cycle. At 0, one of:
    - code!=stop: code=code+1 mod 2^SETTING_W, go to SETTLE.
    - code==stop and cont_mode=1: code=start_code, go to SETTLE.
    - code==stop and cont_mode=0: go to DONE.
  - DONE: done=1, lo_en=0, meas_valid=0, busy=0 for exactly one cycle, then IDLE. lo_setting holds the last code until IDLE clears it.
  - HOLD: lo_en=0, meas_valid=0, busy=1, code retained. When ext_req=0: reload settle counter, go to SETTLE with the same code. The dwell restarts in full.
- Wrap-around: stop_code<start_code sweeps through 2^SETTING_W-1 to 0. start_code==stop_code gives a single code.
- Per-code timing: SETTLE_CYCLES + max(dwell,1) cycles with lo_en=1. meas_valid is high for the last max(dwell,1) of those cycles.
- Priority in SETTLE/DWELL/HOLD: abort > ext_req > counter progress.
  - abort=1: go to IDLE next cycle, done not pulsed.
  - ext_req=1 in SETTLE/DWELL: go to HOLD next cycle, counters discarded.
- start while busy is ignored. Reset mid-sweep returns to IDLE with all outputs 0 on the next edge.

Optional Feature:
Macro LO_SWEEP_STEP_COUNT_EN.
- Defined: adds output step_count[7:0].
  - Cleared when start is accepted.
  - Increments on each DWELL completion; saturates at 255.
  - Holds its value in IDLE/DONE; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. start_code=2, stop_code=4, dwell=3, cont_mode=0, start pulsed at edge k -> lo_setting 2,3,4 for 11 cycles each from k+1; meas_valid high on cycles 9-11 of each code; done=1 only at cycle k+34; lo_en=0 and busy=0 from k+34.
2. start_code=6, stop_code=1, dwell=1 -> lo_setting sequence 6,7,0,1 then done; 36 active cycles.
3. start_code=stop_code=5, cont_mode=1, dwell=2 -> code 5 repeats with a full settle every 10 cycles, no done; abort pulse -> next cycle IDLE, all outputs 0, done never asserted.
4. ext_req raised on the 2nd DWELL cycle of code 3 -> ext_gnt=1 next cycle, state HOLD (lo_en=0, meas_valid=0, busy=1); ext_req dropped -> SETTLE with code 3, 8 settle cycles, then full dwell.
5. dwell=0 -> 1 meas_valid cycle per code; start re-pulsed mid-sweep -> ignored, latched range unchanged; start with ext_req=1 in IDLE -> ignored.
6. rst asserted during DWELL -> next edge all outputs 0 and state IDLE. With LO_SWEEP_STEP_COUNT_EN defined, step_count=0 after reset and 3 after scenario 1.
